// File: rtl/state_seq_arbiter.sv
// Round-robin arbiter sequencing one shared resource through idle/grant/own/drain phases.
// Grants are registered one-hot; ownership is capped at HOLD_MAX cycles per grant.
package state_seq_pkg;
  typedef enum logic [1:0] {
    VAL_A = 2'd0,
    VAL_B = 2'd1,
    VAL_C = 2'd2,
    VAL_D = 2'd3
  } state_t;
endpackage

// One grant bit: loaded with the arbitration result, cleared when ownership ends.
module ssa_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [IDW-1:0] win_i,
  input  logic           clr_i,
  output logic           gnt_o
);
  logic gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      gnt_q <= 1'b0;
    else if (clr_i)  gnt_q <= 1'b0;
    else if (load_i) gnt_q <= (win_i == IDW'(LANE));
  end

  assign gnt_o = gnt_q;
endmodule

module state_seq_arbiter
  import state_seq_pkg::*;
#(
  parameter int  NREQ      = 4,
  parameter int  HOLD_MAX  = 8,
  parameter int  DRAIN_CYC = 2,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            rel_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output state_t          state_o,
  output logic            timeout_o,
  output logic [7:0]      grant_count_o
);
  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [7:0]     hold_q, hold_d;
  logic [3:0]     drain_q, drain_d;
  logic           tmo_q, tmo_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           found;
  logic [IDW-1:0] win;
  logic           rel_exit, lim_exit, own_exit, drain_done;
  logic           gnt_load, gnt_clr;

  // Rotating priority: scan starts just past the last owner and wraps.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(rr_q) + i) % NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign rel_exit   = rel_i | ~req_i[gid_q];
  assign lim_exit   = (hold_q == 8'(HOLD_MAX - 1));
  assign own_exit   = rel_exit | lim_exit;
  assign drain_done = (drain_q == 4'(DRAIN_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VAL_A;
      rr_q    <= IDW'(NREQ - 1);
      gid_q   <= '0;
      hold_q  <= '0;
      drain_q <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VAL_A: if (found)      state_d = VAL_B;
      VAL_B:                 state_d = VAL_C;
      VAL_C: if (own_exit)   state_d = VAL_D;
      VAL_D: if (drain_done) state_d = VAL_A;
      default:               state_d = VAL_A;
    endcase
  end

  always_comb begin
    rr_d     = rr_q;
    gid_d    = gid_q;
    hold_d   = hold_q;
    drain_d  = drain_q;
    tmo_d    = 1'b0;
    cnt_d    = cnt_q;
    gnt_load = 1'b0;
    gnt_clr  = 1'b0;
    unique case (state_q)
      VAL_A: if (found) begin
        rr_d     = win;
        gid_d    = win;
        cnt_d    = cnt_q + 8'd1;
        gnt_load = 1'b1;
      end
      VAL_B: hold_d = '0;
      VAL_C: begin
        hold_d = hold_q + 8'd1;
        if (own_exit) begin
          gnt_clr = 1'b1;
          drain_d = '0;
          // A release in the limit cycle is a normal release, not a timeout.
          tmo_d   = lim_exit & ~rel_exit;
        end
      end
      VAL_D: drain_d = drain_done ? 4'd0 : drain_q + 4'd1;
      default: ;
    endcase
  end

  for (genvar l = 0; l < NREQ; l++) begin : g_lane
    ssa_lane #(.IDW(IDW), .LANE(l)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (gnt_load),
      .win_i  (win),
      .clr_i  (gnt_clr),
      .gnt_o  (gnt_o[l])
    );
  end

  assign gnt_id_o      = gid_q;
  assign state_o       = state_q;
  assign timeout_o     = tmo_q;
  assign grant_count_o = cnt_q;
endmodule
